rep_seq_checker: RTL and testbench

- Synthesisable, multi-channel checker for the property `$rose(trig) |-> b[=N] ##1 c`, with an alternate goto mode `$rose(trig) |-> b[->N] ##1 c`.
- Each property is evaluated as a bounded-time FSM rather than a simulation-only assertion.
- Sits beside the DUT in bench and emulation builds; each channel produces pass/fail pulses, an error code and saturating pass/fail counters.

---
 rtl/rep_seq_checker.sv | 177 +++++++++++++++++
 tb/tb_rep_seq_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_seq_checker.sv
// rep_seq_checker
//   Multi-channel, bounded-time checker for the property
//     $rose(trig) |-> b[=REP_N] ##1 c     (MODE = 0, non-consecutive)
//     $rose(trig) |-> b[->REP_N] ##1 c    (MODE = 1, goto)
//   Each channel runs its own IDLE/COUNT/WAIT_C FSM with a MAX_WAIT cycle bound,
//   and reports registered pass/fail pulses, a failure code and saturating counters.
//
// Ports
//   clk          clock, all sampling on posedge
//   rst          asynchronous active-high reset
//   i_trig       per-channel antecedent; a rising edge starts an attempt
//   i_b          per-channel repeated event
//   i_c          per-channel terminating event
//   o_busy       attempt in progress (through the cycle of the pass/fail pulse)
//   o_pass       one-cycle pulse, attempt matched
//   o_fail       one-cycle pulse, attempt failed
//   o_err_code   2 bits/channel, last failure: 00 none, 01 extra b, 10 missed c, 11 timeout
//   o_drop       sticky, a trig rise arrived while an attempt was running
//   o_pass_cnt   CNT_W bits/channel, saturating pass count
//   o_fail_cnt   CNT_W bits/channel, saturating fail count
module rep_seq_checker #(
    parameter int unsigned NUM_CH   = 1,
    parameter int unsigned REP_N    = 3,
    parameter int unsigned MODE     = 0,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       i_trig,
    input  logic [NUM_CH-1:0]       i_b,
    input  logic [NUM_CH-1:0]       i_c,
    output logic [NUM_CH-1:0]       o_busy,
    output logic [NUM_CH-1:0]       o_pass,
    output logic [NUM_CH-1:0]       o_fail,
    output logic [2*NUM_CH-1:0]     o_err_code,
    output logic [NUM_CH-1:0]       o_drop,
    output logic [CNT_W*NUM_CH-1:0] o_pass_cnt,
    output logic [CNT_W*NUM_CH-1:0] o_fail_cnt
);

    localparam int unsigned RW = $clog2(REP_N + 1);
    localparam int unsigned AW = $clog2(MAX_WAIT);

    localparam logic [RW-1:0]    RepLast = RW'(REP_N);
    localparam logic [AW-1:0]    AgeLast = AW'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrExtraB  = 2'b01;
    localparam logic [1:0] ErrMissC   = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [1:0] {StIdle, StCount, StWaitC} state_t;

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        state_t            r_state;
        logic [RW-1:0]     r_rep;
        logic [AW-1:0]     r_age;
        logic              r_trig_q;
        logic              r_busy;
        logic              r_pass;
        logic              r_fail;
        logic              r_drop;
        logic [1:0]        r_err;
        logic [CNT_W-1:0]  r_pass_cnt;
        logic [CNT_W-1:0]  r_fail_cnt;

        state_t            w_state_nxt;
        logic              w_rise;
        logic              w_pass_dec;
        logic              w_fail_dec;
        logic [1:0]        w_code;
        logic [RW-1:0]     w_rep_inc;
        logic [AW-1:0]     w_age_nxt;

        assign w_rise    = i_trig[g] & ~r_trig_q;
        assign w_rep_inc = r_rep + RW'(1);
        // r_age holds the index of the previous sampled cycle (trigger = 0), so
        // w_age_nxt is the index of the cycle being sampled now.
        assign w_age_nxt = r_age + AW'(1);

        always_comb begin
            w_state_nxt = r_state;
            w_pass_dec  = 1'b0;
            w_fail_dec  = 1'b0;
            w_code      = ErrNone;
            unique case (r_state)
                StIdle: begin
                    // A b in the trigger cycle already counts as occurrence 1.
                    if (w_rise) begin
                        w_state_nxt = (RW'(i_b[g]) == RepLast) ? StWaitC : StCount;
                    end
                end
                StCount: begin
                    if (i_b[g] && (w_rep_inc == RepLast)) begin
                        w_state_nxt = StWaitC;
                    end
                end
                StWaitC: begin
                    if (i_c[g]) begin
                        w_pass_dec = 1'b1;
                    end else if (MODE == 1) begin
                        w_fail_dec = 1'b1;
                        w_code     = ErrMissC;
                    end else if (i_b[g]) begin
                        w_fail_dec = 1'b1;
                        w_code     = ErrExtraB;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
            // Timeout only applies when nothing else was decided this cycle.
            if ((r_state != StIdle) && !w_pass_dec && !w_fail_dec && (w_age_nxt == AgeLast)) begin
                w_fail_dec = 1'b1;
                w_code     = ErrTimeout;
            end
            if (w_pass_dec || w_fail_dec) begin
                w_state_nxt = StIdle;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= StIdle;
                r_rep      <= '0;
                r_age      <= '0;
                r_trig_q   <= 1'b0;
                r_busy     <= 1'b0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_drop     <= 1'b0;
                r_err      <= ErrNone;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else begin
                r_trig_q <= i_trig[g];
                r_state  <= w_state_nxt;
                r_pass   <= w_pass_dec;
                r_fail   <= w_fail_dec;
                r_busy   <= (w_state_nxt != StIdle) || w_pass_dec || w_fail_dec;
                if (w_fail_dec) begin
                    r_err <= w_code;
                end
                if ((r_state != StIdle) && w_rise) begin
                    r_drop <= 1'b1;
                end
                if (r_state == StIdle) begin
                    if (w_rise) begin
                        r_rep <= RW'(i_b[g]);
                        r_age <= '0;
                    end
                end else begin
                    r_age <= w_age_nxt;
                    if ((r_state == StCount) && i_b[g]) begin
                        r_rep <= w_rep_inc;
                    end
                end
                if (r_pass && (r_pass_cnt != CntMax)) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
                if (r_fail && (r_fail_cnt != CntMax)) begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
            end
        end

        assign o_busy[g]                      = r_busy;
        assign o_pass[g]                      = r_pass;
        assign o_fail[g]                      = r_fail;
        assign o_drop[g]                      = r_drop;
        assign o_err_code[2*g +: 2]           = r_err;
        assign o_pass_cnt[CNT_W*g +: CNT_W]   = r_pass_cnt;
        assign o_fail_cnt[CNT_W*g +: CNT_W]   = r_fail_cnt;
    end

endmodule

// File: tb/tb_rep_seq_checker.sv
// Bench for rep_seq_checker: dut0 is a 2-channel non-consecutive checker, dut1 a
// 1-channel goto checker. Expected pulses go into a queue when a scenario starts;
// a negedge monitor pops and compares whenever any channel pulses pass or fail.
module tb_rep_seq_checker;

    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      trig0, b0, c0;
    logic [1:0]      busy0, pass0, fail0, drop0;
    logic [3:0]      err0;
    logic [2*CW-1:0] pcnt0, fcnt0;

    logic [0:0]      trig1, b1, c1;
    logic [0:0]      busy1, pass1, fail1, drop1;
    logic [1:0]      err1;
    logic [CW-1:0]   pcnt1, fcnt1;

    rep_seq_checker #(
        .NUM_CH(2), .REP_N(3), .MODE(0), .MAX_WAIT(16), .CNT_W(CW)
    ) dut0 (
        .clk(clk), .rst(rst),
        .i_trig(trig0), .i_b(b0), .i_c(c0),
        .o_busy(busy0), .o_pass(pass0), .o_fail(fail0),
        .o_err_code(err0), .o_drop(drop0),
        .o_pass_cnt(pcnt0), .o_fail_cnt(fcnt0)
    );

    rep_seq_checker #(
        .NUM_CH(1), .REP_N(3), .MODE(1), .MAX_WAIT(16), .CNT_W(CW)
    ) dut1 (
        .clk(clk), .rst(rst),
        .i_trig(trig1), .i_b(b1), .i_c(c1),
        .o_busy(busy1), .o_pass(pass1), .o_fail(fail1),
        .o_err_code(err1), .o_drop(drop1),
        .o_pass_cnt(pcnt1), .o_fail_cnt(fcnt1)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic        is_pass;
        logic [1:0]  code;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned base = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Source 0/1 = dut0 channel 0/1, source 2 = dut1 channel 0.
    logic [2:0] mp, mf;
    logic [1:0] me [3];
    assign mp    = {pass1[0], pass0[1], pass0[0]};
    assign mf    = {fail1[0], fail0[1], fail0[0]};
    assign me[0] = err0[1:0];
    assign me[1] = err0[3:2];
    assign me[2] = err1;

    int mon_idx;
    always @(negedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 3; s++) begin
                if (mp[s] || mf[s]) begin
                    mon_idx = -1;
                    for (int i = 0; i < q.size(); i++) begin
                        if ((q[i].src == 2'(s)) && (mon_idx < 0)) mon_idx = i;
                    end
                    n_cmp++;
                    if (mon_idx < 0) begin
                        n_bad++;
                        $display("FAIL pulse src%0d: got unexpected pass=%0b fail=%0b code=%0d at cycle %0d, want no pulse",
                                 s, mp[s], mf[s], me[s], cyc - base);
                    end else begin
                        if ((mp[s] !== q[mon_idx].is_pass) || (mf[s] !== ~q[mon_idx].is_pass) ||
                            (me[s] !== q[mon_idx].code) || (cyc != q[mon_idx].cyc)) begin
                            n_bad++;
                            $display("FAIL pulse src%0d: got pass=%0b fail=%0b code=%0d edge %0d, want pass=%0b code=%0d edge %0d",
                                     s, mp[s], mf[s], me[s], cyc - base, q[mon_idx].is_pass,
                                     q[mon_idx].code, q[mon_idx].cyc - base);
                        end
                        q.delete(mon_idx);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bit_at(input int e);
        logic [31:0] m;
        m    = '0;
        m[e] = 1'b1;
        return m;
    endfunction

    task automatic expect_pulse(input int src, input bit is_pass, input logic [1:0] code,
                                input int edge_n);
        exp_t x;
        x.src     = 2'(src);
        x.is_pass = is_pass;
        x.code    = code;
        x.cyc     = base + edge_n;
        q.push_back(x);
    endtask

    task automatic zero_inputs();
        trig0 = '0; b0 = '0; c0 = '0;
        trig1 = '0; b1 = '0; c1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
    endtask

    // Bit e of each mask is the input value sampled at edge e after reset.
    task automatic run(input int n,
                       input logic [31:0] t00, input logic [31:0] b00, input logic [31:0] c00,
                       input logic [31:0] t01, input logic [31:0] b01, input logic [31:0] c01,
                       input logic [31:0] t10, input logic [31:0] b10, input logic [31:0] c10,
                       input bit chk_busy, input logic [31:0] busy_m);
        for (int e = 1; e <= n; e++) begin
            trig0 = {t01[e], t00[e]};
            b0    = {b01[e], b00[e]};
            c0    = {c01[e], c00[e]};
            trig1 = t10[e];
            b1    = b10[e];
            c1    = c10[e];
            @(posedge clk);
            @(negedge clk);
            if (chk_busy) check($sformatf("busy0 after edge %0d", e), 32'(busy0[0]), 32'(busy_m[e]));
        end
        zero_inputs();
    endtask

    task automatic drain(input string name);
        check({name, " pending pulses"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();

        // Reset state
        do_reset();
        check("reset busy0", 32'(busy0), 0);
        check("reset err0", 32'(err0), 0);
        check("reset pcnt0", 32'(pcnt0), 0);
        check("reset drop1", 32'(drop1), 0);

        // MODE 0: three b, no c -> timeout decided at edge 17 (age 15)
        expect_pulse(0, 1'b0, 2'b11, 17);
        run(20, rng(2, 20), bit_at(3) | bit_at(5) | bit_at(7), '0,
            '0, '0, '0, '0, '0, '0, 1'b1, rng(2, 17));
        drain("timeout");
        check("timeout err ch0", 32'(err0[1:0]), 3);
        check("timeout fail_cnt ch0", 32'(fcnt0[CW-1:0]), 1);
        check("timeout pass_cnt ch0", 32'(pcnt0[CW-1:0]), 0);

        // MODE 0, two channels: ch0 passes at edge 10, ch1 fails extra-b at edge 9
        do_reset();
        expect_pulse(0, 1'b1, 2'b00, 10);
        expect_pulse(1, 1'b0, 2'b01, 9);
        run(14, rng(2, 14), bit_at(3) | bit_at(5) | bit_at(7), bit_at(10),
            rng(2, 14), bit_at(3) | bit_at(5) | bit_at(7) | bit_at(9), bit_at(11),
            '0, '0, '0, 1'b1, rng(2, 10));
        drain("two channel");
        check("pass err ch0", 32'(err0[1:0]), 0);
        check("pass pass_cnt ch0", 32'(pcnt0[CW-1:0]), 1);
        check("pass fail_cnt ch0", 32'(fcnt0[CW-1:0]), 0);
        check("extra-b err ch1", 32'(err0[3:2]), 1);
        check("extra-b fail_cnt ch1", 32'(fcnt0[2*CW-1:CW]), 1);
        check("extra-b pass_cnt ch1", 32'(pcnt0[2*CW-1:CW]), 0);
        check("busy after two channel", 32'(busy0), 0);

        // MODE 1: c one cycle after the third b -> pass at edge 8
        do_reset();
        expect_pulse(2, 1'b1, 2'b00, 8);
        run(12, '0, '0, '0, '0, '0, '0,
            rng(2, 12), bit_at(3) | bit_at(5) | bit_at(7), bit_at(8), 1'b0, '0);
        drain("goto pass");
        check("goto pass_cnt", 32'(pcnt1), 1);
        check("goto pass err", 32'(err1), 0);

        // MODE 1: c one cycle late -> missed-c fail decided at edge 8
        do_reset();
        expect_pulse(2, 1'b0, 2'b10, 8);
        run(12, '0, '0, '0, '0, '0, '0,
            rng(2, 12), bit_at(3) | bit_at(5) | bit_at(7), bit_at(9), 1'b0, '0);
        drain("goto miss");
        check("goto miss err", 32'(err1), 2);
        check("goto miss fail_cnt", 32'(fcnt1), 1);
        check("goto miss pass_cnt", 32'(pcnt1), 0);

        // Retrigger while busy sets drop; reset mid-COUNT aborts silently
        do_reset();
        run(5, bit_at(2) | bit_at(4) | bit_at(5), bit_at(3), '0,
            '0, '0, '0, '0, '0, '0, 1'b1, rng(2, 5));
        check("overlap drop ch0", 32'(drop0[0]), 1);
        check("overlap drop ch1", 32'(drop0[1]), 0);
        rst = 1'b1;
        #1;
        check("abort busy0", 32'(busy0), 0);
        check("abort drop0", 32'(drop0), 0);
        check("abort pcnt0", 32'(pcnt0), 0);
        check("abort fcnt0", 32'(fcnt0), 0);
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        run(20, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b1, '0);
        drain("abort");
        check("abort fcnt0 later", 32'(fcnt0), 0);
        check("abort drop0 later", 32'(drop0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
